// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t       : controller states (IDLE, RUN, DONE), 2-bit encoding
//   DEFAULT_WIDTH : default operand/result width
//   cnt_w()       : bit-step counter width for a given operand width
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder used as the arithmetic core of the
// bit-serial adder.
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_sum    : sum bit
//   o_carry  : carry out
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_b & i_c) | (i_a & i_c);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one bit per clock through a single full-adder
// cell, carry held in a register between bit-steps.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request a new addition (sampled in IDLE or DONE only)
//   a, b  : operands, captured on the accepting edge
//   cin   : carry-in, captured on the accepting edge
//   busy  : high while bit-steps are in progress
//   done  : one-cycle pulse when sum/cout take a new value
//   sum   : result, held until the next result is ready
//   cout  : final carry-out, held like sum
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_cell_sum;
  logic             w_cell_carry;

  serial_fa_cell u_fa (
    .i_a    (r_opa[0]),
    .i_b    (r_opb[0]),
    .i_c    (r_carry),
    .o_sum  (w_cell_sum),
    .o_carry(w_cell_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Accept: sum/cout deliberately left alone until the new result lands
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so after WIDTH steps bit 0 is the LSB
          r_res   <= {w_cell_sum, r_res[WIDTH-1:1]};
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          r_carry <= w_cell_carry;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            r_sum   <= {w_cell_sum, r_res[WIDTH-1:1]};
            r_cout  <= w_cell_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int vec_cnt = 0;
  int miscmp  = 0;
  int done8_cnt = 0;
  int done4_cnt = 0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 8-bit instance: an accepted operation produces
  // a+b+cin exactly 8 clock edges later; while that countdown runs the
  // block is busy and ignores start.
  int         m_rem  = 0;
  bit         m_done = 1'b0;
  logic [8:0] m_res  = '0;
  logic [8:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_res  = '0;
      m_pend = '0;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (start8) begin
        m_pend = 9'(a8) + 9'(b8) + 9'(cin8);
        m_rem  = 8;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    check("busy8", 64'(busy8), 64'(m_rem != 0));
    check("done8", 64'(done8), 64'(m_done));
    check("result8", 64'({cout8, sum8}), 64'(m_res));
    if (done8 === 1'b1) done8_cnt++;
    if (done4 === 1'b1) done4_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done8(inout int k);
    while (done8 !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    int k;
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({name, "_busy"}, 64'(busy8), 64'd1);
    k = 0;
    wait_done8(k);
    check({name, "_latency"}, 64'(k), 64'd8);
    check({name, "_sum"}, 64'(sum8), 64'(exp_sum));
    check({name, "_cout"}, 64'(cout8), 64'(exp_cout));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int k;
    logic [4:0] expv;
    expv = 5'(a) + 5'(b) + 5'(cin);
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    k = 0;
    while (done4 !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("w4_latency", 64'(k), 64'd4);
    check("w4_result", 64'({cout4, sum4}), 64'(expv));
  endtask

  initial begin
    int k, d0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'({cout8, sum8}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic add, then hold through idle cycles
    d0 = done8_cnt;
    op8("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    check("model_pin_08", 64'(m_res), 64'h008);
    repeat (20) tick();
    check("hold_sum", 64'({cout8, sum8}), 64'h008);
    check("hold_done_count", 64'(done8_cnt - d0), 64'd1);

    // Carry boundaries
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    check("model_pin_100", 64'(m_res), 64'h100);
    op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    tick();

    // start held high: back-to-back accept in the DONE cycle
    d0 = done8_cnt;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'hAA; b8 = 8'h55;
    k = 0;
    wait_done8(k);
    check("b2b_first_latency", 64'(k), 64'd8);
    check("b2b_first_sum", 64'({cout8, sum8}), 64'h030);
    tick();
    k = 1;
    check("b2b_second_busy", 64'(busy8), 64'd1);
    wait_done8(k);
    start8 = 1'b0;
    check("b2b_spacing", 64'(k), 64'd9);
    check("b2b_second_sum", 64'({cout8, sum8}), 64'h0FF);
    repeat (12) tick();
    check("b2b_done_count", 64'(done8_cnt - d0), 64'd2);

    // start pulsed during RUN is ignored
    d0 = done8_cnt;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    k = 4;
    wait_done8(k);
    check("midrun_latency", 64'(k), 64'd8);
    check("midrun_sum", 64'({cout8, sum8}), 64'h046);
    repeat (12) tick();
    check("midrun_done_count", 64'(done8_cnt - d0), 64'd1);

    // Asynchronous reset in the middle of an operation
    d0 = done8_cnt;
    a8 = 8'h55; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    check("arst_sum", 64'({cout8, sum8}), 64'd0);
    rst_n = 1'b1;
    repeat (15) tick();
    check("arst_no_done", 64'(done8_cnt - d0), 64'd0);
    check("arst_idle_busy", 64'(busy8), 64'd0);

    // WIDTH=4 exhaustive
    d0 = done4_cnt;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          op4(4'(ia), 4'(ib), 1'(ic));
    tick();
    check("w4_done_count", 64'(done4_cnt - d0), 64'd512);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
